// File: rtl/asap_mem_arbiter_if.sv
// Requester handshakes and external 8-bit memory bus of the ASAP CPU memory arbiter.
// slave is the arbiter's view; master is the requesters' plus memory's view.
interface asap_mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [7:0]        ls_wdata;
    logic              ls_gnt;
    logic              ls_done;

    logic [7:0]        rdata;
    logic              err;

    logic [7:0]        bus_out;
    logic [7:0]        bus_oe;
    logic [7:0]        bus_in;
    logic              mem_ale;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_rdy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, bus_in, mem_rdy,
        output if_gnt, if_done, ls_gnt, ls_done, rdata, err,
               bus_out, bus_oe, mem_ale, mem_rd, mem_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, bus_in, mem_rdy,
        input  if_gnt, if_done, ls_gnt, ls_done, rdata, err,
               bus_out, bus_oe, mem_ale, mem_rd, mem_wr
    );
endinterface

// File: rtl/asap_mem_arbiter.sv
// Round-robin arbiter and phase sequencer sharing one 8-bit external memory bus
// between instruction fetch (IF) and load/store (LS), with a wait-state timeout.
module asap_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    asap_mem_arbiter_if.slave arb
);

    typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, DATA} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t            state;
    owner_t            owner;
    owner_t            rr_last;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [7:0]        wdata;
    logic [7:0]        wait_cnt;

    logic              if_done_q;
    logic              ls_done_q;
    logic [7:0]        rdata_q;
    logic              err_q;
    logic [7:0]        bus_out_q;
    logic [7:0]        bus_oe_q;
    logic              ale_q;
    logic              rd_q;
    logic              wr_q;

    logic              grant_if;
    logic              grant_ls;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_ext;
    logic              data_end;

    // IF wins when alone or when LS held the bus last; LS takes every other case it asks in.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE) begin
            if (arb.if_req && (!arb.ls_req || rr_last == OWN_LS)) begin
                grant_if = 1'b1;
            end else if (arb.ls_req) begin
                grant_ls = 1'b1;
            end
        end
    end

    assign sel_addr = grant_if ? arb.if_addr : arb.ls_addr;
    assign sel_ext  = 16'(sel_addr);
    assign data_end = arb.mem_rdy || (wait_cnt == 8'(WAIT_MAX - 1));

    // Outputs are loaded on the edge that enters each phase, so they always describe the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            rr_last   <= OWN_LS;
            addr      <= '0;
            we        <= 1'b0;
            wdata     <= 8'h00;
            wait_cnt  <= 8'h00;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
            bus_out_q <= 8'h00;
            bus_oe_q  <= 8'h00;
            ale_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_ls) begin
                        owner    <= grant_if ? OWN_IF : OWN_LS;
                        rr_last  <= grant_if ? OWN_IF : OWN_LS;
                        addr     <= sel_addr;
                        we       <= grant_ls & arb.ls_we;
                        wdata    <= arb.ls_wdata;
                        bus_oe_q <= 8'hFF;
                        ale_q    <= 1'b1;
                        if (ADDR_W == 16) begin
                            state     <= ADDR_HI;
                            bus_out_q <= sel_ext[15:8];
                        end else begin
                            state     <= ADDR_LO;
                            bus_out_q <= sel_ext[7:0];
                        end
                    end
                end
                ADDR_HI: begin
                    state     <= ADDR_LO;
                    bus_out_q <= addr[7:0];
                end
                ADDR_LO: begin
                    state    <= DATA;
                    ale_q    <= 1'b0;
                    wait_cnt <= 8'h00;
                    if (we) begin
                        bus_out_q <= wdata;
                        bus_oe_q  <= 8'hFF;
                        wr_q      <= 1'b1;
                    end else begin
                        bus_out_q <= 8'h00;
                        bus_oe_q  <= 8'h00;
                        rd_q      <= 1'b1;
                    end
                end
                DATA: begin
                    if (data_end) begin
                        state     <= IDLE;
                        bus_out_q <= 8'h00;
                        bus_oe_q  <= 8'h00;
                        rd_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        err_q     <= !arb.mem_rdy;
                        if (owner == OWN_IF) begin
                            if_done_q <= 1'b1;
                        end else begin
                            ls_done_q <= 1'b1;
                        end
                        // A timed-out read returns zero; writes leave the last read data alone.
                        if (!we) begin
                            rdata_q <= arb.mem_rdy ? arb.bus_in : 8'h00;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign arb.if_gnt  = grant_if;
    assign arb.ls_gnt  = grant_ls;
    assign arb.if_done = if_done_q;
    assign arb.ls_done = ls_done_q;
    assign arb.rdata   = rdata_q;
    assign arb.err     = err_q;
    assign arb.bus_out = bus_out_q;
    assign arb.bus_oe  = bus_oe_q;
    assign arb.mem_ale = ale_q;
    assign arb.mem_rd  = rd_q;
    assign arb.mem_wr  = wr_q;

endmodule

// File: tb/tb_asap_mem_arbiter.sv
// Directed bench for asap_mem_arbiter: a per-cycle vector table on an 8-bit-address
// instance plus hand sequences for round-robin, timeout, mid-transaction reset and 16-bit addressing.
module tb_asap_mem_arbiter;

    logic clk;
    logic rst_n;

    asap_mem_arbiter_if #(.ADDR_W(8))  a8();
    asap_mem_arbiter_if #(.ADDR_W(16)) a16();

    asap_mem_arbiter #(.ADDR_W(8), .WAIT_MAX(15)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (a8)
    );

    asap_mem_arbiter #(.ADDR_W(16), .WAIT_MAX(15)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (a16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       if_req;
        logic [7:0] if_addr;
        logic       ls_req;
        logic       ls_we;
        logic [7:0] ls_addr;
        logic [7:0] ls_wdata;
        logic [7:0] bus_in;
        logic       mem_rdy;
        logic       e_if_gnt;
        logic       e_ls_gnt;
        logic       e_if_done;
        logic       e_ls_done;
        logic [7:0] e_rdata;
        logic       e_err;
        logic [7:0] e_bus_out;
        logic [7:0] e_bus_oe;
        logic       e_ale;
        logic       e_rd;
        logic       e_wr;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    int n_checks;
    int n_fail;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a8.if_req   = v.if_req;
        a8.if_addr  = v.if_addr;
        a8.ls_req   = v.ls_req;
        a8.ls_we    = v.ls_we;
        a8.ls_addr  = v.ls_addr;
        a8.ls_wdata = v.ls_wdata;
        a8.bus_in   = v.bus_in;
        a8.mem_rdy  = v.mem_rdy;
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d if_gnt", i),  32'(a8.if_gnt),  32'(v.e_if_gnt));
        checkOutput($sformatf("v%0d ls_gnt", i),  32'(a8.ls_gnt),  32'(v.e_ls_gnt));
        checkOutput($sformatf("v%0d if_done", i), 32'(a8.if_done), 32'(v.e_if_done));
        checkOutput($sformatf("v%0d ls_done", i), 32'(a8.ls_done), 32'(v.e_ls_done));
        checkOutput($sformatf("v%0d rdata", i),   32'(a8.rdata),   32'(v.e_rdata));
        checkOutput($sformatf("v%0d err", i),     32'(a8.err),     32'(v.e_err));
        checkOutput($sformatf("v%0d bus_out", i), 32'(a8.bus_out), 32'(v.e_bus_out));
        checkOutput($sformatf("v%0d bus_oe", i),  32'(a8.bus_oe),  32'(v.e_bus_oe));
        checkOutput($sformatf("v%0d mem_ale", i), 32'(a8.mem_ale), 32'(v.e_ale));
        checkOutput($sformatf("v%0d mem_rd", i),  32'(a8.mem_rd),  32'(v.e_rd));
        checkOutput($sformatf("v%0d mem_wr", i),  32'(a8.mem_wr),  32'(v.e_wr));
    endtask

    // One transaction on the 8-bit instance; rdy_delay = DATA cycles before mem_rdy rises, -1 = never.
    task automatic runTxn(input bit use_ls, input bit we, input logic [7:0] addr, input logic [7:0] wd,
                          input int rdy_delay, input logic [7:0] bv,
                          output int lat, output int strobe_cycles, output logic got_err,
                          output logic [7:0] got_data, output bit timed_out);
        int  cyc;
        int  data_cyc;
        bit  granted;
        bit  done;
        cyc = 0; data_cyc = 0; granted = 0; done = 0;
        lat = 0; strobe_cycles = 0; got_err = 1'b0; got_data = 8'h00;
        @(posedge clk); #1;
        if (use_ls) begin
            a8.ls_req = 1'b1; a8.ls_we = we; a8.ls_addr = addr; a8.ls_wdata = wd;
        end else begin
            a8.if_req = 1'b1; a8.if_addr = addr;
        end
        a8.bus_in = bv;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (!granted) begin
                if (use_ls ? a8.ls_gnt : a8.if_gnt) granted = 1;
            end else begin
                lat++;
                if (use_ls ? a8.ls_done : a8.if_done) begin
                    done = 1; got_err = a8.err; got_data = a8.rdata;
                end
            end
            if (a8.mem_rd || a8.mem_wr) begin
                strobe_cycles++;
                data_cyc++;
                a8.mem_rdy = (rdy_delay >= 0) && (data_cyc > rdy_delay);
            end else begin
                a8.mem_rdy = 1'b0;
            end
            @(posedge clk); #1;
            if (granted) begin a8.if_req = 1'b0; a8.ls_req = 1'b0; end
            a8.mem_rdy = 1'b0;
            cyc++;
        end
        timed_out = !done;
    endtask

    int          lat, sc;
    logic        e;
    logic [7:0]  d;
    bit          to;
    int          gnt_owner[4];
    int          gnt_cycle[4];
    logic        gnt_with_done[4];
    int          n_gnt, cyc;
    bit          seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // fields: if_req if_addr ls_req ls_we ls_addr ls_wdata bus_in mem_rdy | if_gnt ls_gnt if_done ls_done rdata err bus_out bus_oe ale rd wr
        vecs[0]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 8'h5A, 8'h00, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h07, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        a8.if_req = 0; a8.if_addr = 0; a8.ls_req = 0; a8.ls_we = 0; a8.ls_addr = 0;
        a8.ls_wdata = 0; a8.bus_in = 0; a8.mem_rdy = 0;
        a16.if_req = 0; a16.if_addr = 0; a16.ls_req = 0; a16.ls_we = 0; a16.ls_addr = 0;
        a16.ls_wdata = 0; a16.bus_in = 0; a16.mem_rdy = 0;

        #12;
        checkOutput("reset bus_oe",  32'(a8.bus_oe),  32'h00);
        checkOutput("reset bus_out", 32'(a8.bus_out), 32'h00);
        checkOutput("reset strobes", 32'({a8.mem_ale, a8.mem_rd, a8.mem_wr}), 32'h0);
        checkOutput("reset done/err", 32'({a8.if_done, a8.ls_done, a8.err}), 32'h0);
        checkOutput("reset rdata",   32'(a8.rdata),   32'h00);
        checkOutput("reset bus_oe16", 32'(a16.bus_oe), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(i, vecs[i]);
        end

        // Round-robin with both requesters held high from reset.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        a8.if_req = 1'b1; a8.if_addr = 8'h21;
        a8.ls_req = 1'b1; a8.ls_we = 1'b0; a8.ls_addr = 8'h42;
        a8.bus_in = 8'h11; a8.mem_rdy = 1'b1;
        n_gnt = 0; cyc = 0;
        while (n_gnt < 4 && cyc < 40) begin
            @(negedge clk);
            if (a8.if_gnt || a8.ls_gnt) begin
                checkOutput($sformatf("rr one gnt %0d", n_gnt), 32'(a8.if_gnt & a8.ls_gnt), 32'h0);
                gnt_owner[n_gnt]     = a8.ls_gnt ? 1 : 0;
                gnt_cycle[n_gnt]     = cyc;
                gnt_with_done[n_gnt] = a8.if_done | a8.ls_done;
                n_gnt++;
            end
            cyc++;
            if (n_gnt < 4) @(posedge clk);
        end
        @(posedge clk); #1;
        a8.if_req = 1'b0; a8.ls_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (a8.ls_done) seen = 1;
        end
        a8.mem_rdy = 1'b0;
        checkOutput("rr grant count", 32'(n_gnt), 32'd4);
        checkOutput("rr last done", 32'(seen), 32'd1);
        for (int k = 0; k < n_gnt; k++) begin
            checkOutput($sformatf("rr owner %0d", k), 32'(gnt_owner[k]), 32'(k % 2));
            if (k > 0) begin
                checkOutput($sformatf("rr spacing %0d", k), 32'(gnt_cycle[k] - gnt_cycle[k-1]), 32'd3);
                checkOutput($sformatf("rr gnt with done %0d", k), 32'(gnt_with_done[k]), 32'd1);
            end
        end

        // LS read timeout, then a normal IF read, an LS write with one wait state and an LS write timeout.
        runTxn(1'b1, 1'b0, 8'h55, 8'h00, -1, 8'hEE, lat, sc, e, d, to);
        checkOutput("tmo rd finished", 32'(to), 32'd0);
        checkOutput("tmo rd mem_rd cycles", 32'(sc), 32'd15);
        checkOutput("tmo rd latency", 32'(lat), 32'd17);
        checkOutput("tmo rd err", 32'(e), 32'd1);
        checkOutput("tmo rd rdata", 32'(d), 32'h00);
        runTxn(1'b0, 1'b0, 8'h66, 8'h00, 0, 8'h9B, lat, sc, e, d, to);
        checkOutput("after tmo finished", 32'(to), 32'd0);
        checkOutput("after tmo latency", 32'(lat), 32'd3);
        checkOutput("after tmo err", 32'(e), 32'd0);
        checkOutput("after tmo rdata", 32'(d), 32'h9B);
        runTxn(1'b1, 1'b1, 8'hF0, 8'hC7, 1, 8'h00, lat, sc, e, d, to);
        checkOutput("wr 1ws latency", 32'(lat), 32'd4);
        checkOutput("wr 1ws mem_wr cycles", 32'(sc), 32'd2);
        checkOutput("wr 1ws rdata kept", 32'(d), 32'h9B);
        runTxn(1'b1, 1'b1, 8'hF1, 8'h3E, -1, 8'h00, lat, sc, e, d, to);
        checkOutput("tmo wr latency", 32'(lat), 32'd17);
        checkOutput("tmo wr err", 32'(e), 32'd1);
        checkOutput("tmo wr rdata kept", 32'(d), 32'h9B);

        // Reset asserted during the DATA phase of an IF read.
        @(posedge clk); #1;
        a8.if_req = 1'b1; a8.if_addr = 8'h3C; a8.mem_rdy = 1'b0;
        @(negedge clk);
        checkOutput("rst-mid gnt", 32'(a8.if_gnt), 32'd1);
        @(posedge clk); #1;
        a8.if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst-mid in data", 32'(a8.mem_rd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst-mid bus_oe", 32'(a8.bus_oe), 32'h00);
        checkOutput("rst-mid strobes", 32'({a8.mem_ale, a8.mem_rd, a8.mem_wr}), 32'h0);
        checkOutput("rst-mid rdata", 32'(a8.rdata), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a8.if_done || a8.ls_done) seen = 1;
        end
        checkOutput("rst-mid no done", 32'(seen), 32'd0);
        @(posedge clk); #1;
        a8.if_req = 1'b1; a8.ls_req = 1'b1; a8.ls_we = 1'b0;
        @(negedge clk);
        checkOutput("rst-mid if first", 32'({a8.if_gnt, a8.ls_gnt}), 32'h2);
        @(posedge clk); #1;
        a8.if_req = 1'b0; a8.ls_req = 1'b0; a8.mem_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1 a8.mem_rdy = 1'b0;

        // 16-bit address: two ALE phases, high byte first.
        @(posedge clk); #1;
        a16.if_req = 1'b1; a16.if_addr = 16'h12C4; a16.bus_in = 8'h77;
        @(negedge clk);
        checkOutput("a16 gnt", 32'(a16.if_gnt), 32'd1);
        @(posedge clk); #1;
        a16.if_req = 1'b0;
        @(negedge clk);
        checkOutput("a16 hi phase", 32'({a16.mem_ale, a16.bus_out}), 32'h112);
        @(negedge clk);
        checkOutput("a16 lo phase", 32'({a16.mem_ale, a16.bus_out}), 32'h1C4);
        @(negedge clk);
        checkOutput("a16 data rd", 32'({a16.mem_rd, a16.bus_oe}), 32'h100);
        a16.mem_rdy = 1'b1;
        @(negedge clk);
        a16.mem_rdy = 1'b0;
        checkOutput("a16 done", 32'(a16.if_done), 32'd1);
        checkOutput("a16 rdata", 32'(a16.rdata), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
